match_run_detector: RTL and testbench
=====================================

# match_run_detector

Parametrised successor to the two-input equality sequence detector. It compares two WIDTH-bit inputs every enabled clock and tracks the number of consecutive cycles on which they match (mode 0) or differ (mode 1). It asserts `z` once the run reaches RUN_LEN and counts detection events for software or higher-level control. It sits in the same lab-FSM library and replaces the fixed 1-bit, 4-cycle detector.

## Interface
- `WIDTH`, 1, bit width of `w1`/`w2` (≥1)
- `RUN_LEN`, 4, consecutive qualifying samples required for detection (≥1)
- `HIT_W`, 8, width of the detection-event counter (≥1)
- `CNT_W`, derived = clog2(RUN_LEN+1), width of `run`; not overridden

- `Clock`  in  1  single clock, all state updates on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `en`  in  1  sample enable; when 0, all state holds
- `mode`  in  1  0: qualify when w1==w2; 1: qualify when w1!=w2 (any bit differs)
- `w1`  in  WIDTH  operand 1
- `w2`  in  WIDTH  operand 2
- `clear_hits`  in  1  synchronous clear of `hits` and `hit_ovf`
- `z`  out  1  detection flag, high while run == RUN_LEN
- `run`  out  CNT_W  current consecutive-qualifying count, saturating at RUN_LEN
- `hits`  out  HIT_W  number of detection events since reset/clear, saturating
- `hit_ovf`  out  1  sticky; set when a hit occurs with `hits` already at all-ones

## Operation
- Qualify: q = (mode==0) ? (w1==w2) : (w1!=w2).
- Internal `mode_q` registers `mode` every cycle (regardless of `en`); mode_chg = (mode != mode_q).
- State is the run counter; conceptual states:
  - IDLE: run=0
  - COUNT: 0<run<RUN_LEN
  - DETECT: run=RUN_LEN
- Priority per edge, highest first:
  1. Reset: run=0, mode_q=0, hits=0, hit_ovf=0.
  2. mode_chg: run←0, no hit, regardless of `en`/q.
  3. !en: run holds.
  4. en & !q: run←0.
  5. en & q: run←min(run+1, RUN_LEN).
- Detections overlap/persist: in DETECT with continued qualifying samples, run stays RUN_LEN and `z` stays high. There is no re-arm gap.
- hit event = en & q & !mode_chg & (run == RUN_LEN-1). This is the transition into DETECT, so exactly one event per run.
- hits update:
  - clear_hits & hit: hits←1, hit_ovf←0.
  - clear_hits only: hits←0, hit_ovf←0.
  - hit only, hits==all-ones: hits holds, hit_ovf←1.
  - hit only, otherwise: hits←hits+1.
- RUN_LEN=1: first qualifying sample from IDLE is a hit.
- Reset asserted mid-run discards the run; no hit is recorded on that edge even if one would have occurred.

## Timing
- All outputs are registered or decoded from registers only. There is no combinational path from any input to any output.
- `z` = (run == RUN_LEN). It rises on the edge that samples the RUN_LEN-th consecutive qualifying input, visible in the following cycle.
- `z` falls on the edge that samples a non-qualifying input or a mode change.
- `hits` increments on the same edge that `z` rises.
- `clear_hits` takes effect on the next edge; its effect is visible the following cycle.
- Reset values: z=0, run=0, hits=0, hit_ovf=0.
- Throughput: one sample per enabled cycle; `en` gaps do not break a run.

## Test plan
- Default params, mode=0, w1=w2 for 4 enabled cycles:
  - z=0 after edges 1–3; z=1 and hits=1 after edge 4.
  - 2 more equal cycles: z stays 1, hits stays 1.
- Same, but w1≠w2 on cycle 3: run→0, z never rises. Then 4 equal cycles: hits=1.
- WIDTH=4, mode=1:
  - w1=4'hA, w2=4'h5 ×4: hits=1.
  - w1=w2=4'h3 one cycle: z=0, run=0.
- en gaps: equal, en=0 ×3 (inputs unequal), equal, equal, equal → z=1 after the 4th enabled edge. Toggling mode mid-run → run=0 next cycle.
- HIT_W=2: produce 4 separate runs → hits=3, hit_ovf=1.
  - clear_hits on the same edge as a 5th hit → hits=1, hit_ovf=0.
- Reset asserted on the edge that would complete a run (run=3, qualifying input) → z=0, run=0, hits=0 the next cycle. RUN_LEN=1: a single qualifying sample gives z=1, hits=1.

Source files
------------

// File: rtl/match_run_detector.sv
// Consecutive match/mismatch run detector: counts qualifying samples up to RUN_LEN,
// flags detection while the run is complete and tallies detection events.
module match_run_detector #(
  parameter int WIDTH   = 1,
  parameter int RUN_LEN = 4,
  parameter int HIT_W   = 8,
  parameter int CNT_W   = $clog2(RUN_LEN + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] w1,
  input  logic [WIDTH-1:0] w2,
  input  logic             clear_hits,
  output logic             z,
  output logic [CNT_W-1:0] run,
  output logic [HIT_W-1:0] hits,
  output logic             hit_ovf
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] RUN_PRE = CNT_W'(RUN_LEN - 1);

  logic [CNT_W-1:0] run_q, run_d;
  logic [HIT_W-1:0] hits_q, hits_d;
  logic             hit_ovf_q, hit_ovf_d;
  logic             mode_q, mode_d;
  logic             qual, mode_chg, hit;

  always_comb begin
    qual      = mode ? (w1 != w2) : (w1 == w2);
    mode_chg  = (mode != mode_q);
    hit       = en & qual & ~mode_chg & (run_q == RUN_PRE);
    mode_d    = mode;
    run_d     = run_q;
    hits_d    = hits_q;
    hit_ovf_d = hit_ovf_q;

    // A mode change restarts the run even when sampling is disabled.
    if (mode_chg) begin
      run_d = '0;
    end else if (en) begin
      if (!qual) begin
        run_d = '0;
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + 1'b1;
      end
    end

    // A clear coinciding with a hit keeps that hit in the fresh tally.
    if (clear_hits) begin
      hits_d    = hit ? HIT_W'(1) : '0;
      hit_ovf_d = 1'b0;
    end else if (hit) begin
      if (&hits_q) begin
        hit_ovf_d = 1'b1;
      end else begin
        hits_d = hits_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      run_q     <= '0;
      mode_q    <= 1'b0;
      hits_q    <= '0;
      hit_ovf_q <= 1'b0;
    end else begin
      run_q     <= run_d;
      mode_q    <= mode_d;
      hits_q    <= hits_d;
      hit_ovf_q <= hit_ovf_d;
    end
  end

  assign z       = (run_q == RUN_MAX);
  assign run     = run_q;
  assign hits    = hits_q;
  assign hit_ovf = hit_ovf_q;

endmodule

// File: tb/tb_match_run_detector.sv
// Bench for match_run_detector: three parameterisations share stimulus; directed
// scenarios use fixed expectations, a random phase is scored against a run model.
module tb_match_run_detector;

  logic       Clock;
  logic       Reset;
  logic       en;
  logic       mode;
  logic [3:0] w1;
  logic [3:0] w2;
  logic       clear_hits;

  // a: defaults (WIDTH=1, RUN_LEN=4, HIT_W=8)
  logic       z_a, ovf_a;
  logic [2:0] run_a;
  logic [7:0] hits_a;
  // b: WIDTH=4, RUN_LEN=4, HIT_W=2
  logic       z_b, ovf_b;
  logic [2:0] run_b;
  logic [1:0] hits_b;
  // c: WIDTH=3, RUN_LEN=1, HIT_W=3
  logic       z_c, ovf_c;
  logic [0:0] run_c;
  logic [2:0] hits_c;

  int checks = 0;
  int errors = 0;

  match_run_detector u_a (
    .Clock(Clock), .Reset(Reset), .en(en), .mode(mode), .w1(w1[0]), .w2(w2[0]),
    .clear_hits(clear_hits), .z(z_a), .run(run_a), .hits(hits_a), .hit_ovf(ovf_a)
  );

  match_run_detector #(.WIDTH(4), .RUN_LEN(4), .HIT_W(2)) u_b (
    .Clock(Clock), .Reset(Reset), .en(en), .mode(mode), .w1(w1), .w2(w2),
    .clear_hits(clear_hits), .z(z_b), .run(run_b), .hits(hits_b), .hit_ovf(ovf_b)
  );

  match_run_detector #(.WIDTH(3), .RUN_LEN(1), .HIT_W(3)) u_c (
    .Clock(Clock), .Reset(Reset), .en(en), .mode(mode), .w1(w1[2:0]), .w2(w2[2:0]),
    .clear_hits(clear_hits), .z(z_c), .run(run_c), .hits(hits_c), .hit_ovf(ovf_c)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: run length as an integer, hit = run reaching its target.
  int m_run [3];
  int m_hits[3];
  bit m_ovf [3];
  bit m_prev_mode[3];
  int rl   [3] = '{4, 4, 1};
  int hmax [3] = '{255, 3, 7};
  int wbits[3] = '{1, 4, 3};

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int a, b, nxt;
      bit q, hit;
      if (Reset) begin
        m_run[i] = 0; m_hits[i] = 0; m_ovf[i] = 0; m_prev_mode[i] = 0;
        continue;
      end
      a   = int'(w1) % (1 << wbits[i]);
      b   = int'(w2) % (1 << wbits[i]);
      q   = mode ? (a != b) : (a == b);
      hit = 0;
      if (mode != m_prev_mode[i]) m_run[i] = 0;
      else if (en && !q) m_run[i] = 0;
      else if (en && q) begin
        nxt = (m_run[i] + 1 > rl[i]) ? rl[i] : m_run[i] + 1;
        hit = (nxt == rl[i]) && (m_run[i] < rl[i]);
        m_run[i] = nxt;
      end
      if (clear_hits) begin
        m_hits[i] = hit ? 1 : 0;
        m_ovf[i]  = 0;
      end else if (hit) begin
        if (m_hits[i] == hmax[i]) m_ovf[i] = 1;
        else m_hits[i]++;
      end
      m_prev_mode[i] = mode;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input bit e, input bit m, input logic [3:0] a, input logic [3:0] b);
    en = e; mode = m; w1 = a; w2 = b;
  endtask

  task automatic do_reset();
    Reset = 1'b1; clear_hits = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 4'h0);
    tick(); tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (z_a !== 1'b0)     begin errors++; $display("FAIL reset_z: got %0b expected 0", z_a); end
    checks++; if (run_a !== 3'd0)   begin errors++; $display("FAIL reset_run: got %0d expected 0", run_a); end
    checks++; if (hits_a !== 8'd0)  begin errors++; $display("FAIL reset_hits: got %0d expected 0", hits_a); end
    checks++; if (ovf_a !== 1'b0)   begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf_a); end
    checks++; if (hits_b !== 2'd0)  begin errors++; $display("FAIL reset_hits_b: got %0d expected 0", hits_b); end
  endtask

  task automatic test_basic_run();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b1, 1'b0, 4'h0, 4'h0);
      tick();
      checks++; if (z_a !== (k >= 4)) begin errors++; $display("FAIL basic_z[%0d]: got %0b expected %0b", k, z_a, k >= 4); end
      checks++; if (run_a !== 3'((k > 4) ? 4 : k)) begin errors++; $display("FAIL basic_run[%0d]: got %0d expected %0d", k, run_a, (k > 4) ? 4 : k); end
      checks++; if (hits_a !== 8'((k >= 4) ? 1 : 0)) begin errors++; $display("FAIL basic_hits[%0d]: got %0d expected %0d", k, hits_a, (k >= 4) ? 1 : 0); end
    end
  endtask

  task automatic test_break();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) drive(1'b1, 1'b0, 4'h1, 4'h0);
      else        drive(1'b1, 1'b0, 4'h1, 4'h1);
      tick();
      checks++; if (z_a !== 1'b0) begin errors++; $display("FAIL break_z[%0d]: got %0b expected 0", k, z_a); end
    end
    checks++; if (run_a !== 3'd0) begin errors++; $display("FAIL break_run: got %0d expected 0", run_a); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 4'h1, 4'h1);
      tick();
    end
    checks++; if (z_a !== 1'b1)    begin errors++; $display("FAIL break_z_after: got %0b expected 1", z_a); end
    checks++; if (hits_a !== 8'd1) begin errors++; $display("FAIL break_hits: got %0d expected 1", hits_a); end
  endtask

  task automatic test_mode1();
    do_reset();
    drive(1'b0, 1'b1, 4'hA, 4'h5);  // mode change cycle, restarts the run
    tick();
    checks++; if (run_b !== 3'd0) begin errors++; $display("FAIL mode1_prime_run: got %0d expected 0", run_b); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 4'hA, 4'h5);
      tick();
    end
    checks++; if (hits_b !== 2'd1) begin errors++; $display("FAIL mode1_hits: got %0d expected 1", hits_b); end
    checks++; if (z_b !== 1'b1)    begin errors++; $display("FAIL mode1_z: got %0b expected 1", z_b); end
    drive(1'b1, 1'b1, 4'h3, 4'h3);
    tick();
    checks++; if (z_b !== 1'b0)   begin errors++; $display("FAIL mode1_eq_z: got %0b expected 0", z_b); end
    checks++; if (run_b !== 3'd0) begin errors++; $display("FAIL mode1_eq_run: got %0d expected 0", run_b); end
  endtask

  task automatic test_en_gaps();
    do_reset();
    drive(1'b1, 1'b0, 4'h0, 4'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 4'h1, 4'h0);
      tick();
    end
    checks++; if (run_a !== 3'd1) begin errors++; $display("FAIL gap_hold_run: got %0d expected 1", run_a); end
    for (int k = 2; k <= 4; k++) begin
      drive(1'b1, 1'b0, 4'h1, 4'h1);
      tick();
      checks++; if (z_a !== (k == 4)) begin errors++; $display("FAIL gap_z[%0d]: got %0b expected %0b", k, z_a, k == 4); end
    end
    do_reset();
    drive(1'b1, 1'b0, 4'h0, 4'h0);
    tick(); tick();
    checks++; if (run_a !== 3'd2) begin errors++; $display("FAIL toggle_pre_run: got %0d expected 2", run_a); end
    drive(1'b1, 1'b1, 4'h1, 4'h0);
    tick();
    checks++; if (run_a !== 3'd0) begin errors++; $display("FAIL toggle_run: got %0d expected 0", run_a); end
  endtask

  task automatic test_hit_sat();
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1'b1, 1'b0, 4'h7, 4'h7);
        tick();
      end
      drive(1'b1, 1'b0, 4'h1, 4'h2);
      tick();
    end
    checks++; if (hits_b !== 2'd3) begin errors++; $display("FAIL sat_hits: got %0d expected 3", hits_b); end
    checks++; if (ovf_b !== 1'b1)  begin errors++; $display("FAIL sat_ovf: got %0b expected 1", ovf_b); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 4'h7, 4'h7);
      clear_hits = (k == 3);
      tick();
    end
    clear_hits = 1'b0;
    checks++; if (hits_b !== 2'd1) begin errors++; $display("FAIL clr_hit_hits: got %0d expected 1", hits_b); end
    checks++; if (ovf_b !== 1'b0)  begin errors++; $display("FAIL clr_hit_ovf: got %0b expected 0", ovf_b); end
  endtask

  task automatic test_reset_mid_and_len1();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 4'h0, 4'h0);
      tick();
    end
    checks++; if (run_a !== 3'd3) begin errors++; $display("FAIL mid_pre_run: got %0d expected 3", run_a); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    checks++; if (z_a !== 1'b0)    begin errors++; $display("FAIL mid_z: got %0b expected 0", z_a); end
    checks++; if (run_a !== 3'd0)  begin errors++; $display("FAIL mid_run: got %0d expected 0", run_a); end
    checks++; if (hits_a !== 8'd0) begin errors++; $display("FAIL mid_hits: got %0d expected 0", hits_a); end
    drive(1'b1, 1'b0, 4'h5, 4'h5);
    tick();
    checks++; if (z_c !== 1'b1)    begin errors++; $display("FAIL len1_z: got %0b expected 1", z_c); end
    checks++; if (hits_c !== 3'd1) begin errors++; $display("FAIL len1_hits: got %0d expected 1", hits_c); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [3:0] a;
      a = 4'($urandom);
      Reset      = ($urandom_range(0, 199) == 0);
      clear_hits = ($urandom_range(0, 31) == 0);
      en         = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      w1 = a;
      w2 = ($urandom_range(0, 4) != 0) ? a : 4'($urandom);
      tick();
      checks++; if (z_a !== (m_run[0] == 4)) begin errors++; $display("FAIL rnd_z_a[%0d]: got %0b expected %0b", n, z_a, m_run[0] == 4); end
      checks++; if (run_a !== 3'(m_run[0]))  begin errors++; $display("FAIL rnd_run_a[%0d]: got %0d expected %0d", n, run_a, m_run[0]); end
      checks++; if (hits_a !== 8'(m_hits[0])) begin errors++; $display("FAIL rnd_hits_a[%0d]: got %0d expected %0d", n, hits_a, m_hits[0]); end
      checks++; if (ovf_a !== m_ovf[0])       begin errors++; $display("FAIL rnd_ovf_a[%0d]: got %0b expected %0b", n, ovf_a, m_ovf[0]); end
      checks++; if (z_b !== (m_run[1] == 4)) begin errors++; $display("FAIL rnd_z_b[%0d]: got %0b expected %0b", n, z_b, m_run[1] == 4); end
      checks++; if (run_b !== 3'(m_run[1]))  begin errors++; $display("FAIL rnd_run_b[%0d]: got %0d expected %0d", n, run_b, m_run[1]); end
      checks++; if (hits_b !== 2'(m_hits[1])) begin errors++; $display("FAIL rnd_hits_b[%0d]: got %0d expected %0d", n, hits_b, m_hits[1]); end
      checks++; if (ovf_b !== m_ovf[1])       begin errors++; $display("FAIL rnd_ovf_b[%0d]: got %0b expected %0b", n, ovf_b, m_ovf[1]); end
      checks++; if (z_c !== (m_run[2] == 1)) begin errors++; $display("FAIL rnd_z_c[%0d]: got %0b expected %0b", n, z_c, m_run[2] == 1); end
      checks++; if (run_c !== 1'(m_run[2]))  begin errors++; $display("FAIL rnd_run_c[%0d]: got %0d expected %0d", n, run_c, m_run[2]); end
      checks++; if (hits_c !== 3'(m_hits[2])) begin errors++; $display("FAIL rnd_hits_c[%0d]: got %0d expected %0d", n, hits_c, m_hits[2]); end
      checks++; if (ovf_c !== m_ovf[2])       begin errors++; $display("FAIL rnd_ovf_c[%0d]: got %0b expected %0b", n, ovf_c, m_ovf[2]); end
    end
    Reset = 1'b0; clear_hits = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; clear_hits = 1'b0;
    en = 1'b0; mode = 1'b0; w1 = 4'h0; w2 = 4'h0;
    test_reset();
    test_basic_run();
    test_break();
    test_mode1();
    test_en_gaps();
    test_hit_sat();
    test_reset_mid_and_len1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
